// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential signed ALU: add/sub in one step, shift-add multiply, sign+magnitude outputs
// Define ALU_DIV_EN to make mode 11 a restoring signed divide; otherwise mode 11 multiplies.
`timescale 1ns/1ps

module alu_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           ar,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  output logic           busy,
  output logic           done,
  output logic           sign,
  output logic           sign_a,
  output logic           sign_b,
  output logic [2*W-1:0] f_out,
  output logic [2*W-1:0] a_out,
`ifdef ALU_DIV_EN
  output logic [2*W-1:0] b_out,
  output logic           div_zero
`else
  output logic [2*W-1:0] b_out
`endif
);

  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [1:0]    op;
  logic [W2-1:0] a_lat;
  logic [W2-1:0] b_lat;
  logic [W2-1:0] acc;
  logic [W2-1:0] op_x;
  logic [W2-1:0] op_y;
  logic [CW-1:0] cnt;

  logic [W2-1:0] a_ext;
  logic [W2-1:0] b_ext;
  logic [W2-1:0] a_mag;
  logic [W2-1:0] b_mag;
  logic [W2-1:0] sum_r;
  logic [W2-1:0] sum_mag;
  logic [W2-1:0] mul_add;

  assign a_ext   = {{W{a[W-1]}}, a};
  assign b_ext   = {{W{b[W-1]}}, b};
  assign a_mag   = a[W-1] ? -a_ext : a_ext;
  assign b_mag   = b[W-1] ? -b_ext : b_ext;
  assign sum_r   = op[0] ? (a_lat - b_lat) : (a_lat + b_lat);
  assign sum_mag = sum_r[W2-1] ? -sum_r : sum_r;
  assign mul_add = op_y[0] ? op_x : '0;

`ifdef ALU_DIV_EN
  // Remainder never exceeds the divisor, so W bits of acc plus the next dividend bit suffice.
  logic [W:0] rem_sh;
  logic [W:0] trial;
  assign rem_sh = {acc[W-1:0], op_x[W-1]};
  assign trial  = rem_sh - {1'b0, op_y[W-1:0]};
`endif

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state  <= IDLE;
      op     <= 2'b00;
      a_lat  <= '0;
      b_lat  <= '0;
      acc    <= '0;
      op_x   <= '0;
      op_y   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sign   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      f_out  <= '0;
      a_out  <= '0;
      b_out  <= '0;
`ifdef ALU_DIV_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat  <= a_ext;
            b_lat  <= b_ext;
            op     <= mode;
            a_out  <= a_mag;
            b_out  <= b_mag;
            sign_a <= a[W-1];
            sign_b <= b[W-1];
            acc    <= '0;
            op_x   <= a_mag;
            op_y   <= b_mag;
            cnt    <= CW'(W);
`ifdef ALU_DIV_EN
            div_zero <= 1'b0;
`endif
            if (mode[1]) begin
              state <= CALC;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end

        CALC: begin
`ifdef ALU_DIV_EN
          if (op == 2'b11) begin
            // Quotient bits shift into op_x from the right as dividend bits leave at the top.
            if (trial[W]) begin
              acc  <= {{W{1'b0}}, rem_sh[W-1:0]};
              op_x <= {op_x[W2-2:0], 1'b0};
            end else begin
              acc  <= {{W{1'b0}}, trial[W-1:0]};
              op_x <= {op_x[W2-2:0], 1'b1};
            end
          end else begin
            acc  <= acc + mul_add;
            op_x <= op_x << 1;
            op_y <= op_y >> 1;
          end
`else
          acc  <= acc + mul_add;
          op_x <= op_x << 1;
          op_y <= op_y >> 1;
`endif
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          if (!op[1]) begin
            f_out <= sum_mag;
            sign  <= sum_r[W2-1];
          end
`ifdef ALU_DIV_EN
          else if (op == 2'b11) begin
            if (b_lat == '0) begin
              f_out    <= '0;
              sign     <= 1'b0;
              div_zero <= 1'b1;
            end else begin
              f_out <= {{W{1'b0}}, op_x[W-1:0]};
              sign  <= (sign_a ^ sign_b) && (op_x[W-1:0] != '0);
            end
          end
`endif
          else begin
            f_out <= acc;
            sign  <= (sign_a ^ sign_b) && (acc != '0);
          end
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
